// File: rtl/cplx_alu.sv
// Complex-number ALU: ADD/SUB/CONJA in one cycle; MUL/MAC over a shared DW x DW
// signed multiplier, producing one partial product per cycle.
module cplx_alu #(
    parameter int DW = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      opcode,
    input  logic [2*DW-1:0] opA,
    input  logic [2*DW-1:0] opB,
    input  logic            clracc,
    output logic [2*DW-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            err
);
    localparam int AW = 2*DW + 2;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_MAC   = 3'b011;
    localparam logic [2:0] OP_CONJA = 3'b100;

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIN} state_t;

    state_t              state_q, state_d;
    logic [2*DW-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic [2*DW-1:0]     result_q, result_d;
    logic                done_q, done_d, err_q, err_d;
    logic [AW-1:0]       acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [2*DW-1:0] p0_q, p1_q, p2_q, p3_q;

    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic [2*DW:0]          re_full, im_full;
    logic [AW-1:0]          acc_re_sum, acc_im_sum;

    assign prod = mul_a * mul_b;

    // Recombine at 2*DW+1 bits so the exact value is available before wrapping.
    assign re_full = {p0_q[2*DW-1], p0_q} - {p1_q[2*DW-1], p1_q};
    assign im_full = {p2_q[2*DW-1], p2_q} + {p3_q[2*DW-1], p3_q};
    assign acc_re_sum = acc_re_q + {re_full[2*DW], re_full};
    assign acc_im_sum = acc_im_q + {im_full[2*DW], im_full};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        mul_a    = '0;
        mul_b    = '0;
        case (state_q)
            IDLE: begin
                // Clearing here also covers a MAC accepted in the same cycle.
                if (clracc) begin
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
                if (start) begin
                    a_d  = opA;
                    b_d  = opB;
                    op_d = opcode;
                    case (opcode)
                        OP_ADD: begin
                            result_d = {opA[2*DW-1:DW] + opB[2*DW-1:DW], opA[DW-1:0] + opB[DW-1:0]};
                            done_d   = 1'b1;
                        end
                        OP_SUB: begin
                            result_d = {opA[2*DW-1:DW] - opB[2*DW-1:DW], opA[DW-1:0] - opB[DW-1:0]};
                            done_d   = 1'b1;
                        end
                        OP_CONJA: begin
                            result_d = {opA[2*DW-1:DW], DW'(-opA[DW-1:0])};
                            done_d   = 1'b1;
                        end
                        OP_MUL, OP_MAC: state_d = P0;
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            P0: begin
                mul_a   = a_q[2*DW-1:DW];
                mul_b   = b_q[2*DW-1:DW];
                state_d = P1;
            end
            P1: begin
                mul_a   = a_q[DW-1:0];
                mul_b   = b_q[DW-1:0];
                state_d = P2;
            end
            P2: begin
                mul_a   = a_q[2*DW-1:DW];
                mul_b   = b_q[DW-1:0];
                state_d = P3;
            end
            P3: begin
                mul_a   = a_q[DW-1:0];
                mul_b   = b_q[2*DW-1:DW];
                state_d = FIN;
            end
            FIN: begin
                if (op_q == OP_MAC) begin
                    acc_re_d = acc_re_sum;
                    acc_im_d = acc_im_sum;
                    result_d = {acc_re_sum[DW-1:0], acc_im_sum[DW-1:0]};
                end else begin
                    result_d = {re_full[DW-1:0], im_full[DW-1:0]};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == P0) p0_q <= prod;
        if (state_q == P1) p1_q <= prod;
        if (state_q == P2) p2_q <= prod;
        if (state_q == P3) p3_q <= prod;
    end

    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
endmodule
